control_unit: RTL

//  Hardwired control sequencer for the CPU datapath. It produces the per-step

---
 rtl/control_unit.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// Hardwired control sequencer: T0-T2 instruction fetch, then IR-decoded execute
// steps for ALU, unary, mul/div, nop, halt and undefined opcodes.
module control_unit #(
    parameter int NREG = 16,
    parameter int OPW  = 5
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [31:0]     IR,
    input  logic            mem_rdy,
    output logic            PCout,
    output logic            MARin,
    output logic            incPC,
    output logic            Zin,
    output logic            ZLowOut,
    output logic            ZHighOut,
    output logic            PCin,
    output logic            Read,
    output logic            MDRin,
    output logic            MDRout,
    output logic            IRin,
    output logic            Yin,
    output logic            HIin,
    output logic            LOin,
    output logic [NREG-1:0] Rin,
    output logic [NREG-1:0] Rout,
    output logic [OPW-1:0]  opcode,
    output logic            run,
    output logic            illegal
);

    localparam logic [3:0] S_RST  = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_HALT = 4'd8;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
    localparam logic [OPW-1:0] OP_SHR  = OPW'(5'b00101);
    localparam logic [OPW-1:0] OP_SHL  = OPW'(5'b00110);
    localparam logic [OPW-1:0] OP_ROR  = OPW'(5'b00111);
    localparam logic [OPW-1:0] OP_ROL  = OPW'(5'b01000);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5'b01001);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5'b01010);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b01110);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b01111);
    localparam logic [OPW-1:0] OP_NEG  = OPW'(5'b10000);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(5'b10001);
    localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

    logic [3:0]     state_q, state_d;
    logic [OPW-1:0] op;
    logic [3:0]     ra, rb, rc;
    logic           is_alu3, is_unary, is_muldiv, is_halt, is_nop, is_illegal;
    logic           unused_ir;

    assign op        = IR[31:32-OPW];
    assign ra        = IR[26:23];
    assign rb        = IR[22:19];
    assign rc        = IR[18:15];
    assign unused_ir = ^IR[14:0];

    function automatic logic [NREG-1:0] onehot(input logic [3:0] idx);
        return NREG'(1) << idx;
    endfunction

    always_comb begin
        is_alu3   = 1'b0;
        is_unary  = 1'b0;
        is_muldiv = 1'b0;
        is_halt   = 1'b0;
        is_nop    = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR:  is_alu3   = 1'b1;
            OP_NEG, OP_NOT:                 is_unary  = 1'b1;
            OP_MUL, OP_DIV:                 is_muldiv = 1'b1;
            OP_NOP:                         is_nop    = 1'b1;
            OP_HALT:                        is_halt   = 1'b1;
            default: ;
        endcase
        is_illegal = !(is_alu3 || is_unary || is_muldiv || is_nop || is_halt);
    end

    // IR is only valid from T3 on, so every class (nop included) passes through T3.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:  state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = mem_rdy ? S_T2 : S_T1;
            S_T2:   state_d = S_T3;
            S_T3: begin
                if (is_alu3 || is_unary || is_muldiv) state_d = S_T4;
                else if (is_halt)                     state_d = S_HALT;
                else                                  state_d = S_T0;
            end
            S_T4:   state_d = is_unary ? S_T0 : S_T5;
            S_T5:   state_d = is_muldiv ? S_T6 : S_T0;
            S_T6:   state_d = S_T0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) state_q <= S_RST;
        else     state_q <= state_d;
    end

    always_comb begin
        PCout    = 1'b0;
        MARin    = 1'b0;
        incPC    = 1'b0;
        Zin      = 1'b0;
        ZLowOut  = 1'b0;
        ZHighOut = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Rin      = '0;
        Rout     = '0;
        opcode   = '0;
        illegal  = 1'b0;
        run      = (state_q >= S_T0) && (state_q <= S_T6);
        case (state_q)
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; incPC = 1'b1; Zin = 1'b1;
            end
            S_T1: begin
                ZLowOut = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                if (is_alu3) begin
                    Rout = onehot(rb); Yin = 1'b1;
                end else if (is_unary) begin
                    Rout = onehot(rb); opcode = op; Zin = 1'b1;
                end else if (is_muldiv) begin
                    Rout = onehot(ra); Yin = 1'b1;
                end
                illegal = is_illegal;
            end
            S_T4: begin
                if (is_alu3) begin
                    Rout = onehot(rc); opcode = op; Zin = 1'b1;
                end else if (is_unary) begin
                    ZLowOut = 1'b1; Rin = onehot(ra);
                end else begin
                    Rout = onehot(rb); opcode = op; Zin = 1'b1;
                end
            end
            S_T5: begin
                ZLowOut = 1'b1;
                if (is_muldiv) LOin = 1'b1;
                else           Rin  = onehot(ra);
            end
            S_T6: begin
                ZHighOut = 1'b1; HIin = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
